memory_responder: RTL
=====================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array.
REQ-002 Parameter ROM_WORDS, default 64: words 0..ROM_WORDS-1 are write-protected (boot region).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 memory_addr  input  32  byte address from the CPU.
REQ-006 data_to_memory  input  32  write data from the CPU.
REQ-007 write_to_memory  input  1  1 = write access, 0 = read access.
REQ-008 data_from_memory  output  32  registered read data.
REQ-009 memory_error  output  1  registered access-fault flag.
REQ-010 write_count  output  16  committed writes, saturating.
REQ-011 error_count  output  8  faulting accesses, saturating.

Function
REQ-012 Word index = memory_addr[31:2]; an access is in range iff index < DEPTH_WORDS.
REQ-013 Read: on each edge with write_to_memory=0, data_from_memory <= mem[index] (1-cycle latency), bit-exact, no byte swapping.
REQ-014 Out-of-range read shall load data_from_memory with 32'h0000_0000.
REQ-015 While write_to_memory=1, data_from_memory shall hold its previous value.
REQ-016 Write FSM states IDLE, WRITE; IDLE -> WRITE on an edge with write_to_memory=1, capturing index into wr_index and data_to_memory into wr_data.
REQ-017 In WRITE, each edge with write_to_memory=1 updates wr_data from data_to_memory; memory_addr changes are ignored (wr_index fixed).
REQ-018 In WRITE, the first edge with write_to_memory=0 commits wr_data to mem[wr_index], increments write_count, returns to IDLE; same edge performs the read of REQ-013 with read-before-write ordering.
REQ-019 A write whose captured index < ROM_WORDS shall not be committed and shall not increment write_count.
REQ-020 Fault conditions: memory_addr[1:0] != 0 at read edge or WRITE entry; out-of-range index; write to ROM region (detected at commit edge).
REQ-021 memory_error is 1 for exactly the cycle following each faulting edge, else 0; error_count increments once per fault.
REQ-022 Misaligned access still uses index memory_addr[31:2] (low bits ignored) and still signals fault.
REQ-023 write_count and error_count shall stop at 16'hFFFF / 8'hFF.
REQ-024 Faulting write (misaligned/out-of-range) shall not be committed; FSM still completes WRITE -> IDLE.

Reset
REQ-025 On rst low: FSM = IDLE, data_from_memory = 0, memory_error = 0, write_count = 0, error_count = 0, wr_index = 0, wr_data = 0.
REQ-026 Reset during WRITE discards the pending write; array contents are not cleared by reset.
REQ-027 Array contents after power-up are undefined unless loaded by the bench.

Configuration
REQ-028 Macro MEM_BOUNDS_CHECK_EN defined: fault detection, memory_error, error_count per REQ-020..REQ-024.
REQ-029 Macro MEM_BOUNDS_CHECK_EN undefined: index wraps modulo DEPTH_WORDS, misalignment ignored, ROM region writable, memory_error and error_count tied 0; write FSM unchanged.

Verification
REQ-030 Preload mem[5]=32'hDEAD_BEEF; addr 32'h14, write=0 -> data_from_memory=32'hDEAD_BEEF next cycle, memory_error=0.
REQ-031 addr 32'h200, write=1 for 3 cycles with data 0,0,32'h1234_5678, then write=0 -> mem[128]=32'h1234_5678, write_count=1; read of 32'h200 returns it.
REQ-032 Write 32'hCAFE_0000 to addr 32'h10 (ROM) -> mem[4] unchanged, memory_error pulses 1 cycle, error_count=1, write_count=0.
REQ-033 Read addr 32'h0000_1002 (misaligned, out of range at DEPTH 1024) -> data_from_memory=0, memory_error=1 one cycle; without MEM_BOUNDS_CHECK_EN -> returns mem[0], memory_error=0.
REQ-034 rst low mid-WRITE at addr 32'h300 -> mem[192] unchanged, all outputs 0, FSM IDLE after release.
REQ-035 Force 300 faulting reads -> error_count saturates at 8'hFF.

Source files
------------

// File: rtl/memory_responder.sv
// Word-addressed memory with a write-protected boot region; faults are checked only with MEM_BOUNDS_CHECK_EN defined.
// Reads return one cycle after the edge; a write is held in WRITE and committed on the first edge with write_to_memory low.
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ROM_WORDS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memory_addr,
  input  logic [31:0] data_to_memory,
  input  logic        write_to_memory,
  output logic [31:0] data_from_memory,
  output logic        memory_error,
  output logic [15:0] write_count,
  output logic [7:0]  error_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic {IDLE, WRITE} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [29:0] wr_index;
  logic [31:0] wr_data;
  logic        wr_bad;

  logic [29:0]   idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_mem_idx;
  logic          misaligned;
  logic          rd_in_range;
  logic          access_bad;
  logic          wr_rom;
  logic          commit_edge;
  logic          do_commit;
  logic          rom_fault;
  logic          access_fault;
  logic [1:0]    n_faults;
  logic [8:0]    err_sum;

  always_comb begin
    idx          = memory_addr[31:2];
    misaligned   = CHECK_EN && (memory_addr[1:0] != 2'b00);
    rd_in_range  = !CHECK_EN || (idx < 30'(DEPTH_WORDS));
    // Without checking the index simply wraps into the array.
    rd_idx       = AW'(idx % 30'(DEPTH_WORDS));
    wr_mem_idx   = AW'(wr_index % 30'(DEPTH_WORDS));
    access_bad   = misaligned || !rd_in_range;
    wr_rom       = CHECK_EN && (wr_index < 30'(ROM_WORDS));
    commit_edge  = (state == WRITE) && !write_to_memory;
    do_commit    = commit_edge && !wr_bad && !wr_rom;
    rom_fault    = commit_edge && !wr_bad && wr_rom;
    // Address faults are judged on read edges and on WRITE entry only.
    access_fault = access_bad && (!write_to_memory || (state == IDLE));
    n_faults     = {1'b0, access_fault} + {1'b0, rom_fault};
    err_sum      = {1'b0, error_count} + {7'd0, n_faults};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      wr_index         <= '0;
      wr_data          <= '0;
      wr_bad           <= 1'b0;
      data_from_memory <= '0;
      memory_error     <= 1'b0;
      write_count      <= '0;
      error_count      <= '0;
    end else begin
      if (!write_to_memory)
        data_from_memory <= rd_in_range ? mem[rd_idx] : 32'h0000_0000;
      memory_error <= |n_faults;
      error_count  <= err_sum[8] ? 8'hFF : err_sum[7:0];
      case (state)
        IDLE: begin
          if (write_to_memory) begin
            state    <= WRITE;
            wr_index <= idx;
            wr_data  <= data_to_memory;
            wr_bad   <= access_bad;
          end
        end
        WRITE: begin
          if (write_to_memory) begin
            wr_data <= data_to_memory;
          end else begin
            state <= IDLE;
            if (do_commit && (write_count != 16'hFFFF))
              write_count <= write_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; the read above samples the old word on a commit edge.
  always_ff @(posedge clk) begin
    if (do_commit)
      mem[wr_mem_idx] <= wr_data;
  end

endmodule
